// File: rtl/apple_gen.sv
// apple_gen: holds the snake-game apple position, detects the head eating it and redraws from an LFSR.
// Optional idle-apple timeout is enabled by defining APPLE_TIMEOUT_EN.
`timescale 1ns/1ps
module apple_gen #(
    parameter int          GRID_W         = 40,
    parameter int          GRID_H         = 30,
    parameter int          INIT_X         = 24,
    parameter int          INIT_Y         = 10,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] game_status,
    input  logic [5:0] head_x,
    input  logic [5:0] head_y,
    output logic [5:0] apple_x,
    output logic [5:0] apple_y,
    output logic       apple_valid,
    output logic       add_cube
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_EAT, S_EAT, S_RELOCATE} state_t;

    localparam logic [1:0] GS_RESTART = 2'b00;
    localparam logic [1:0] GS_PLAY    = 2'b10;
    localparam logic [6:0] GRID_W_L   = 7'(GRID_W);
    localparam logic [6:0] GRID_H_L   = 7'(GRID_H);
    localparam logic [5:0] INIT_X_L   = 6'(INIT_X);
    localparam logic [5:0] INIT_Y_L   = 6'(INIT_Y);

    state_t      state_q, state_d;
    logic [5:0]  apple_x_q, apple_x_d;
    logic [5:0]  apple_y_q, apple_y_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        apple_valid_q, apple_valid_d;
    logic        add_cube_q, add_cube_d;

    logic        is_play;
    logic        head_hit;
    logic [5:0]  cand_x;
    logic [5:0]  cand_y;
    logic        cand_ok;

`ifdef APPLE_TIMEOUT_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;
    logic        timeout_hit;
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        is_play  = (game_status == GS_PLAY);
        head_hit = (head_x == apple_x_q) && (head_y == apple_y_q);
        cand_x   = lfsr_q[5:0];
        cand_y   = lfsr_q[13:8];
        // The head exclusion is what keeps a stale head from re-eating the new apple.
        cand_ok  = ({1'b0, cand_x} < GRID_W_L) && ({1'b0, cand_y} < GRID_H_L) &&
                   !((cand_x == head_x) && (cand_y == head_y));
`ifdef APPLE_TIMEOUT_EN
        timeout_hit = (idle_cnt_q == TIMEOUT_CYCLES - 32'd1);
`endif

        state_d   = state_q;
        apple_x_d = apple_x_q;
        apple_y_d = apple_y_q;
        // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
        lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        case (state_q)
            S_IDLE: begin
                if (is_play) state_d = S_WAIT_EAT;
            end
            S_WAIT_EAT: begin
                if (!is_play)     state_d = S_IDLE;
                else if (head_hit) state_d = S_EAT;
`ifdef APPLE_TIMEOUT_EN
                else if (timeout_hit) state_d = S_RELOCATE;
`endif
            end
            S_EAT: begin
                state_d = S_RELOCATE;
            end
            S_RELOCATE: begin
                if (cand_ok) begin
                    apple_x_d = cand_x;
                    apple_y_d = cand_y;
                    state_d   = is_play ? S_WAIT_EAT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef APPLE_TIMEOUT_EN
        idle_cnt_d = (state_q == S_WAIT_EAT) ? idle_cnt_q + 32'd1 : 32'd0;
`endif

        if (game_status == GS_RESTART) begin
            state_d   = S_IDLE;
            apple_x_d = INIT_X_L;
            apple_y_d = INIT_Y_L;
            lfsr_d    = LFSR_SEED;
`ifdef APPLE_TIMEOUT_EN
            idle_cnt_d = 32'd0;
`endif
        end

        // Outputs are registered from the next state so they line up with it.
        apple_valid_d = (state_d == S_IDLE) || (state_d == S_WAIT_EAT);
        add_cube_d    = (state_d == S_EAT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            apple_x_q     <= INIT_X_L;
            apple_y_q     <= INIT_Y_L;
            lfsr_q        <= LFSR_SEED;
            apple_valid_q <= 1'b1;
            add_cube_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            apple_x_q     <= apple_x_d;
            apple_y_q     <= apple_y_d;
            lfsr_q        <= lfsr_d;
            apple_valid_q <= apple_valid_d;
            add_cube_q    <= add_cube_d;
        end
    end

`ifdef APPLE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idle_cnt_q <= 32'd0;
        else      idle_cnt_q <= idle_cnt_d;
    end
`endif

    assign apple_x     = apple_x_q;
    assign apple_y     = apple_y_q;
    assign apple_valid = apple_valid_q;
    assign add_cube    = add_cube_q;

endmodule

// File: doc/apple_gen.md
# apple_gen

Apple (food) generator for the snake game; sits directly upstream of the score display. Holds the current apple grid position, detects the snake head reaching it, and emits a one-cycle `add_cube` pulse to the score counter. After each eat it draws a new in-range position from a free-running LFSR. The display and collision logic read `apple_x`/`apple_y`.

## Interface
- `GRID_W`, default 40: grid columns; legal x is 0..GRID_W-1, and GRID_W ≤ 64.
- `GRID_H`, default 30: grid rows; legal y is 0..GRID_H-1, and GRID_H ≤ 64.
- `INIT_X`, default 24: apple x after reset or RESTART.
- `INIT_Y`, default 10: apple y after reset or RESTART.
- `LFSR_SEED`, default 16'hACE1: LFSR value after reset or RESTART; must be non-zero.
- `TIMEOUT_CYCLES`, default 32'd500_000_000: idle-apple timeout, used only with `APPLE_TIMEOUT_EN`.
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: asynchronous, active-low reset.
- `game_status` in 2: 00 RESTART, 01 START, 10 PLAY, 11 DIE.
- `head_x` in 6: snake head column; sampled every cycle.
- `head_y` in 6: snake head row; sampled every cycle.
- `apple_x` out 6: current apple column (registered).
- `apple_y` out 6: current apple row (registered).
- `apple_valid` out 1: high while the apple position is settled and eatable.
- `add_cube` out 1: one-cycle pulse per apple eaten; goes to the score counter.

## Operation
- **LFSR:** 16-bit Fibonacci LFSR, taps 16, 14, 13, 11.
  - Shifts every cycle in every state except reset and RESTART.
  - Candidate position: `cand_x = lfsr[5:0]`, `cand_y = lfsr[13:8]`.
- **FSM states:** IDLE, WAIT_EAT, EAT, RELOCATE.
  - **IDLE:** `apple_valid`=1. When `game_status`==PLAY, go to WAIT_EAT.
  - **WAIT_EAT:** `apple_valid`=1.
    - If `game_status`≠PLAY, go to IDLE. The apple position is kept.
    - Else if `head_x`==`apple_x` and `head_y`==`apple_y`, go to EAT.
  - **EAT:** `add_cube`=1 for exactly this cycle, `apple_valid`=0. Go to RELOCATE unconditionally.
  - **RELOCATE:** `apple_valid`=0, `add_cube`=0. Each cycle, a candidate is accepted only if all of these hold:
    - `cand_x` < GRID_W;
    - `cand_y` < GRID_H;
    - (`cand_x`,`cand_y`) ≠ (`head_x`,`head_y`).
    - On accept: load `apple_x`/`apple_y`, then go to WAIT_EAT if PLAY, else IDLE.
    - On reject: stay in RELOCATE.
    - Worst-case dwell is bounded by the LFSR period; typical dwell is under 4 cycles.
- **RESTART:** `game_status`==RESTART, sampled synchronously, overrides every state.
  - Forces the reset values: state IDLE, `apple_x`/`apple_y`=INIT_X/INIT_Y, LFSR=LFSR_SEED, `add_cube`=0.
- **DIE/START:** no eat detection occurs and the apple position is frozen. An in-progress RELOCATE still completes.
- **Pulse spacing:** `add_cube` never asserts on two consecutive cycles, so the downstream level-edge detector counts each pulse exactly once.

## Timing
- **Reset values (async `rst`=0):**
  - `apple_x`=INIT_X, `apple_y`=INIT_Y, `apple_valid`=1, `add_cube`=0.
  - state IDLE, LFSR=LFSR_SEED.
- **Eat latency:** the head matches at cycle N in WAIT_EAT, then `add_cube`=1 at N+1 (EAT). RELOCATE starts at N+2.
- **New position:** visible on `apple_x`/`apple_y` the cycle after the accepting RELOCATE cycle. `apple_valid` rises on that same cycle.
- **Stale head:** a head still sitting on the old apple coordinates cannot re-trigger, because the new position excludes the head.
- **Reset mid-RELOCATE:** abandons the draw immediately. No `add_cube` is produced.
- **All outputs are registered:** no combinational path from inputs to outputs.

## Configuration
- `APPLE_TIMEOUT_EN` defined:
  - A 32-bit counter runs while in WAIT_EAT.
  - It clears on entry to WAIT_EAT and on RESTART.
  - On reaching TIMEOUT_CYCLES-1 it forces RELOCATE without pulsing `add_cube`, and the score is unchanged.
- `APPLE_TIMEOUT_EN` undefined:
  - The counter is absent and the apple stays put until eaten.

## Test plan
- **Reset:** hold `rst`=0 with defaults, then release. Expect `apple_x`=24, `apple_y`=10, `apple_valid`=1, `add_cube`=0.
- **Single eat:** PLAY, head driven to (24,10). Expect:
  - `add_cube` high for exactly 1 cycle, one cycle after the match;
  - within 64 cycles, `apple_valid`=1 with x<40, y<30 and position ≠ (24,10).
- **No eat outside PLAY:** `game_status`=DIE, head on the apple for 100 cycles. Expect `add_cube` to stay 0 and the position unchanged.
- **RESTART mid-RELOCATE:** assert RESTART in the cycle after EAT. Expect:
  - next cycle: (24,10), state IDLE;
  - after returning to PLAY, the LFSR sequence repeats bit-exact from the seed.
- **Range soak:** 1000 forced eats with random heads. Verify every accepted position is in range and never equals the head. `add_cube` count must be 1000, and no two pulses are adjacent.
- **Timeout (`APPLE_TIMEOUT_EN`, TIMEOUT_CYCLES=100):** PLAY with the head away from the apple. Expect a relocation after 100 cycles with `add_cube`=0 throughout.
